pipe_ctrl: RTL

Parametrised pipeline sequencing controller for the WISC pipelined core. It replaces the scattered per-stage write-enable, flush and halt logic with one block. The block owns:
- per-pipeline-register valid bits and load enables
- bubble insertion on load-use stalls
- front-end flush on taken branch/jump
- whole-pipe freeze on multi-cycle memory busy
- halt drain sequencing
- retire and cycle performance counters

It sits beside the hazard and forwarding units and drives PC write and every inter-stage register enable.

---
 rtl/pipe_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: owns inter-stage valid bits and load enables,
// load-use bubbles, branch flush, memory-busy freeze, HLT drain and perf counters.
module pipe_ctrl #(
  parameter int STAGES = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic              imem_busy,
  input  logic              dmem_busy,
  input  logic              load_use_stall,
  input  logic              redirect,
  input  logic              halt_dec,
  output logic              pc_we,
  output logic [STAGES-2:0] preg_we,
  output logic [STAGES-2:0] preg_valid,
  output logic              retire,
  output logic              hlt,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int PREGS = STAGES - 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  state_e             state_q, state_d;
  logic [PREGS-1:0]   valid_q, valid_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   retire_q, retire_d;

  logic               freeze;
  logic               halt_take;
  logic [PREGS-1:0]   shifted;

  assign freeze    = imem_busy | dmem_busy;
  assign halt_take = (state_q == ST_RUN) & halt_dec & valid_q[0];
  assign shifted   = {valid_q[PREGS-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    pc_we   = 1'b0;
    preg_we = '0;

    if (state_q == ST_HALTED) begin
      pend_d = 1'b0;
    end else if (freeze) begin
      // A branch resolved while frozen must still flush once the pipe moves.
      pend_d = pend_q | redirect;
    end else if (load_use_stall) begin
      preg_we    = {{(PREGS-1){1'b1}}, 1'b0};
      valid_d    = shifted;
      valid_d[0] = valid_q[0];
      valid_d[1] = 1'b0;
    end else begin
      preg_we = '1;
      pend_d  = 1'b0;
      valid_d = shifted;
      if (halt_take) begin
        state_d = ST_DRAIN;
      end else if (state_q == ST_RUN) begin
        pc_we      = 1'b1;
        valid_d[0] = (redirect | pend_q) ? 1'b0 : fetch_valid;
      end
    end

    if ((state_q == ST_DRAIN) && (valid_q == '0)) begin
      state_d = ST_HALTED;
    end
  end

  assign retire   = valid_q[PREGS-1] & ~freeze;
  assign cycle_d  = (state_q != ST_HALTED) ? cycle_q + CNT_W'(1) : cycle_q;
  assign retire_d = retire ? retire_q + CNT_W'(1) : retire_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      valid_q  <= '0;
      pend_q   <= 1'b0;
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      pend_q   <= pend_d;
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
    end
  end

  assign preg_valid = valid_q;
  assign hlt        = (state_q == ST_HALTED);
  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;

endmodule
